dff_misr_checker: RTL and testbench

DFF_MISR_CHECKER -- requirements
Module: dff_misr_checker

---
 rtl/dff_misr_checker.sv | 117 +++++++++++
 tb/tb_dff_misr_checker.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/dff_misr_checker.sv
// Compacts a DFF_X1 Q bank into a MISR signature and checks every Q/QN pair for complement violations.
// Runs for LEN cycles per START; DONE rises LEN+1 edges after START, or on the next edge when LEN is 0.
module dff_misr_checker #(
    parameter int              WIDTH = 8,
    parameter int              SIGW  = 16,
    parameter logic [SIGW-1:0] POLY  = 16'h1021,
    parameter logic [SIGW-1:0] SEED  = 16'hFFFF
) (
    input  logic             CK,
    input  logic             RST,
    input  logic             START,
    input  logic [7:0]       LEN,
    input  logic [SIGW-1:0]  EXP,
    input  logic [WIDTH-1:0] Q,
    input  logic [WIDTH-1:0] QN,
    output logic             BUSY,
    output logic             DONE,
    output logic             PASS,
    output logic [SIGW-1:0]  SIG,
    output logic             COMP_ERR,
    output logic [7:0]       ERR_CNT
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic [SIGW-1:0] r_sig;
    logic [7:0]      r_cnt;
    logic [SIGW-1:0] r_exp;
    logic            r_pass;
    logic            r_comp_err;
    logic [7:0]      r_err_cnt;

    logic            w_start_acc;
    logic            w_last;
    logic            w_viol;
    logic [SIGW-1:0] w_q_ext;
    logic [SIGW-1:0] w_sig_nxt;

    assign w_start_acc = START && (r_state != ST_RUN);
    assign w_last      = (r_state == ST_RUN) && (r_cnt == 8'd1);
    // Case-inequality so that X/Z on either rail counts as a violation in simulation.
    assign w_viol      = ((Q ^ QN) !== {WIDTH{1'b1}});

    always_comb begin
        w_q_ext = '0;
        w_q_ext[WIDTH-1:0] = Q;
        w_sig_nxt = {r_sig[SIGW-2:0], 1'b0} ^ (r_sig[SIGW-1] ? POLY : '0) ^ w_q_ext;
    end

    // State register plus the datapath registers it steers.
    always_ff @(posedge CK) begin
        if (RST) begin
            r_state    <= ST_IDLE;
            r_sig      <= SEED;
            r_cnt      <= 8'd0;
            r_exp      <= '0;
            r_pass     <= 1'b0;
            r_comp_err <= 1'b0;
            r_err_cnt  <= 8'd0;
        end else begin
            r_state <= w_state_nxt;
            if (w_start_acc) begin
                r_sig      <= SEED;
                r_cnt      <= LEN;
                r_exp      <= EXP;
                r_pass     <= (LEN == 8'd0) ? (SEED == EXP) : 1'b0;
                r_comp_err <= 1'b0;
                r_err_cnt  <= 8'd0;
            end else if (r_state == ST_RUN) begin
                r_sig <= w_sig_nxt;
                r_cnt <= r_cnt - 8'd1;
                if (w_last) begin
                    r_pass <= (w_sig_nxt == r_exp);
                end
                if (w_viol) begin
                    r_comp_err <= 1'b1;
                    if (r_err_cnt != 8'hFF) begin
                        r_err_cnt <= r_err_cnt + 8'd1;
                    end
                end
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE, ST_DONE: begin
                if (START) begin
                    w_state_nxt = (LEN == 8'd0) ? ST_DONE : ST_RUN;
                end
            end
            ST_RUN: begin
                if (r_cnt == 8'd1) begin
                    w_state_nxt = ST_DONE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        BUSY     = (r_state == ST_RUN);
        DONE     = (r_state == ST_DONE);
        PASS     = r_pass;
        SIG      = r_sig;
        COMP_ERR = r_comp_err;
        ERR_CNT  = r_err_cnt;
    end

endmodule

// File: tb/tb_dff_misr_checker.sv
// Directed bench for dff_misr_checker: hand-computed signatures, run timing, error counting and reset priority.
module tb_dff_misr_checker;

    logic        CK = 1'b0;
    logic        RST;
    logic        START;
    logic [7:0]  LEN;
    logic [15:0] EXP;
    logic [7:0]  Q;
    logic [7:0]  QN;
    logic        BUSY;
    logic        DONE;
    logic        PASS;
    logic [15:0] SIG;
    logic        COMP_ERR;
    logic [7:0]  ERR_CNT;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 CK = ~CK;

    dff_misr_checker dut (
        .CK       (CK),
        .RST      (RST),
        .START    (START),
        .LEN      (LEN),
        .EXP      (EXP),
        .Q        (Q),
        .QN       (QN),
        .BUSY     (BUSY),
        .DONE     (DONE),
        .PASS     (PASS),
        .SIG      (SIG),
        .COMP_ERR (COMP_ERR),
        .ERR_CNT  (ERR_CNT)
    );

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // One rising edge, then land on the falling edge where inputs change and outputs are sampled.
    task automatic tick();
        @(posedge CK);
        @(negedge CK);
    endtask

    // Issue a START on the next edge; returns just after that edge.
    task automatic go(input logic [7:0] len, input logic [15:0] e);
        LEN   = len;
        EXP   = e;
        START = 1'b1;
        tick();
        START = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_busy"}, BUSY, 0);
        check({tag, "_done"}, DONE, 0);
        check({tag, "_pass"}, PASS, 0);
        check({tag, "_sig"}, SIG, 32'hFFFF);
        check({tag, "_cerr"}, COMP_ERR, 0);
        check({tag, "_ecnt"}, ERR_CNT, 0);
    endtask

    initial begin
        int k;
        RST = 1'b1; START = 1'b0; LEN = 8'd0; EXP = 16'h0000;
        Q = 8'h00; QN = 8'hFF;
        @(negedge CK);
        tick();
        tick();
        RST = 1'b0;
        check_reset_outputs("reset");

        // Idle: inputs, even violating ones, are neither compacted nor checked
        Q = 8'h5A; QN = 8'h00;
        tick(); tick(); tick();
        check("idle_sig", SIG, 32'hFFFF);
        check("idle_ecnt", ERR_CNT, 0);
        check("idle_busy", BUSY, 0);

        // LEN=1, Q=00: FFFF -> FFFE ^ 1021 = EFDF
        Q = 8'h00; QN = 8'hFF;
        go(8'd1, 16'hEFDF);
        check("l1_busy", BUSY, 1);
        check("l1_done_early", DONE, 0);
        tick();
        check("l1_done", DONE, 1);
        check("l1_busy_off", BUSY, 0);
        check("l1_sig", SIG, 32'hEFDF);
        check("l1_pass", PASS, 1);
        check("l1_cerr", COMP_ERR, 0);

        // LEN=1, Q=01 started from DONE
        Q = 8'h01; QN = 8'hFE;
        go(8'd1, 16'hEFDF);
        check("l1b_busy", BUSY, 1);
        tick();
        check("l1b_done", DONE, 1);
        check("l1b_sig", SIG, 32'hEFDE);
        check("l1b_pass", PASS, 0);

        // LEN=2: EFDF -> DFBE ^ 1021 = CF9F, ^ 5A = CFC5
        Q = 8'h00; QN = 8'hFF;
        go(8'd2, 16'hCFC5);
        tick();
        Q = 8'h5A; QN = 8'hA5;
        tick();
        check("l2_done", DONE, 1);
        check("l2_sig", SIG, 32'hCFC5);
        check("l2_pass", PASS, 1);
        // DONE holds; violating inputs are ignored there
        Q = 8'hFF; QN = 8'hFF;
        tick(); tick();
        check("l2_hold_sig", SIG, 32'hCFC5);
        check("l2_hold_ecnt", ERR_CNT, 0);
        check("l2_hold_done", DONE, 1);
        check("l2_hold_pass", PASS, 1);

        // LEN=0 goes straight to DONE, PASS = (SEED == EXP)
        go(8'd0, 16'hFFFF);
        check("l0_busy", BUSY, 0);
        check("l0_done", DONE, 1);
        check("l0_sig", SIG, 32'hFFFF);
        check("l0_pass", PASS, 1);
        check("l0_ecnt", ERR_CNT, 0);

        // LEN=4 with Q=QN=00 in RUN cycles 2 and 3
        Q = 8'h00; QN = 8'hFF;
        go(8'd4, 16'h0000);
        tick();
        QN = 8'h00;
        tick();
        tick();
        check("l4_busy_e3", BUSY, 1);
        check("l4_done_e3", DONE, 0);
        QN = 8'hFF;
        tick();
        check("l4_done", DONE, 1);
        check("l4_cerr", COMP_ERR, 1);
        check("l4_ecnt", ERR_CNT, 2);

        // LEN=10: violation in cycle 1, START re-pulse in cycle 3 ignored, RST in cycle 6
        Q = 8'h00; QN = 8'h00;
        go(8'd10, 16'h0000);
        tick();
        QN = 8'hFF;
        tick();
        START = 1'b1; LEN = 8'd2;
        tick();
        START = 1'b0;
        check("l10_repulse_ecnt", ERR_CNT, 1);
        check("l10_repulse_busy", BUSY, 1);
        tick();
        tick();
        check("l10_e5_busy", BUSY, 1);
        check("l10_e5_done", DONE, 0);
        RST = 1'b1;
        tick();
        RST = 1'b0;
        check_reset_outputs("midrun_rst");

        // RST wins over a simultaneous START
        RST = 1'b1; START = 1'b1; LEN = 8'd1;
        tick();
        RST = 1'b0; START = 1'b0;
        check("rst_start_busy", BUSY, 0);
        check("rst_start_done", DONE, 0);

        // First START after reset is accepted
        Q = 8'h00; QN = 8'hFF;
        go(8'd1, 16'hEFDF);
        check("post_rst_busy", BUSY, 1);
        tick();
        check("post_rst_pass", PASS, 1);

        // LEN=255, every cycle violated
        Q = 8'h00; QN = 8'h00;
        go(8'd255, 16'h0000);
        k = 0;
        while (DONE !== 1'b1 && k < 300) begin
            tick();
            k++;
        end
        check("l255_edges", k, 255);
        check("l255_ecnt", ERR_CNT, 32'hFF);
        check("l255_cerr", COMP_ERR, 1);
        tick(); tick();
        check("l255_hold_ecnt", ERR_CNT, 32'hFF);
        Q = 8'h00; QN = 8'hFF;
        go(8'd1, 16'h0000);
        check("restart_ecnt", ERR_CNT, 0);
        check("restart_cerr", COMP_ERR, 0);
        check("restart_busy", BUSY, 1);
        tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
